// File: rtl/arbitro_pkg.sv
// Shared definitions for the two-stage arbiter chain (arbitro1_rr feeding arbitro2).
// Word layout: destination field in the top two bits, the rest is opaque payload.
package arbitro_pkg;

    localparam int WIDTH    = 12;
    localparam int N        = 4;
    localparam int DEST_MSB = 11;
    localparam int DEST_LSB = 10;

    typedef logic [WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

endpackage

// File: rtl/arbitro1_rr_if.sv
// Bundle between the four per-class input FIFOs, the arbiter and the shared downstream FIFO.
// master = arbiter side, slave = FIFO/environment side.
interface arbitro1_rr_if;
  import arbitro_pkg::*;

  logic [N-1:0] empty;
  word_t        fifo_in0;
  word_t        fifo_in1;
  word_t        fifo_in2;
  word_t        fifo_in3;
  logic         almost_full;
  logic [N-1:0] pop;
  logic         push;
  word_t        fifo_out;
  logic         idle;

  modport master (
    input  empty, fifo_in0, fifo_in1, fifo_in2, fifo_in3, almost_full,
    output pop, push, fifo_out, idle
  );

  modport slave (
    output empty, fifo_in0, fifo_in1, fifo_in2, fifo_in3, almost_full,
    input  pop, push, fifo_out, idle
  );

endinterface

// File: rtl/rr_grant.sv
// Combinational round-robin picker: searches last+1, last+2, last+3, last+4 (mod 4).
// Zero latency; an all-zero req yields gnt_vld=0 and gnt=0.
module rr_grant (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld
);

  logic [1:0] cand;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = last;
    cand    = last;
    for (int i = 1; i <= 4; i++) begin
      // offset 4 wraps to last itself, so the previous winner is considered last
      cand = last + 2'(i);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt = gnt_vld ? (4'b0001 << gnt_idx) : 4'b0000;
  end

endmodule

// File: rtl/arbitro1_rr.sv
// Round-robin drain of four input FIFOs into one shared FIFO; pop in N, data in N+1, push in N+2.
// almost_full blocks new pops the same cycle; the two in-flight words still push.
module arbitro1_rr
  import arbitro_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  arbitro1_rr_if.master bus
);

  state_t     state_q, state_d;
  logic [1:0] last_q;
  logic [1:0] sel_q;
  logic       vld_q;
  logic       push_q;
  word_t      out_q;
  word_t      sel_word;

  logic       run;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;

  assign run = (state_q != ST_RESET) && !bus.almost_full;
  assign req = ~bus.empty & {4{run}};

  rr_grant u_grant (
    .req     (req),
    .last    (last_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign bus.pop = gnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_IDLE;
      ST_IDLE:   if (gnt_vld)  state_d = ST_ACTIVE;
      ST_ACTIVE: if (!gnt_vld) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Read data of the FIFO popped last cycle is valid now
  always_comb begin
    sel_word = bus.fifo_in0;
    case (sel_q)
      2'd0:    sel_word = bus.fifo_in0;
      2'd1:    sel_word = bus.fifo_in1;
      2'd2:    sel_word = bus.fifo_in2;
      2'd3:    sel_word = bus.fifo_in3;
      default: sel_word = bus.fifo_in0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 2'd3;
      sel_q  <= 2'd0;
      vld_q  <= 1'b0;
      push_q <= 1'b0;
      out_q  <= '0;
    end else begin
      if (gnt_vld) last_q <= gnt_idx;
      sel_q  <= gnt_idx;
      vld_q  <= gnt_vld;
      push_q <= vld_q;
      if (vld_q) out_q <= sel_word;
    end
  end

  assign bus.push     = push_q;
  assign bus.fifo_out = out_q;
  // RESET counts as idle so the output reads 1 while reset is held
  assign bus.idle     = (state_q != ST_ACTIVE) & ~vld_q & ~push_q;

endmodule

// File: tb/tb_arbitro1_rr.sv
// Directed bench for arbitro1_rr: expected pop patterns per step, popped words scoreboarded
// and matched against push/fifo_out with the pop-to-push cycle distance.
module tb_arbitro1_rr;

  logic clk;
  logic reset;

  arbitro1_rr_if bus();

  arbitro1_rr dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] w;
    int          c;
  } sb_t;

  sb_t         sb[$];
  logic [11:0] dat [4];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          npush  = 0;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs at the falling edge, sample 1ns later, then advance to the next falling edge
  task automatic step(input logic [3:0] e, input logic af, input logic [3:0] exp_pop, input string tag);
    sb_t ent;
    bus.empty       = e;
    bus.almost_full = af;
    #1;
    check(tag, 12'(bus.pop), 12'(exp_pop));
    if (bus.push === 1'b1) begin
      npush++;
      if (sb.size() == 0) begin
        check("push_without_pop", 12'(sb.size()), 12'd1);
      end else begin
        ent = sb.pop_front();
        check("push_word", bus.fifo_out, ent.w);
        check("push_latency", 12'(cyc), 12'(ent.c + 2));
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (bus.pop[k] === 1'b1) begin
        ent.w = dat[k];
        ent.c = cyc;
        sb.push_back(ent);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(4'b1111, 1'b0, 4'b0000, "pop_drain");
  endtask

  int p0;

  initial begin
    dat[0] = 12'h296;
    dat[1] = 12'h196;
    dat[2] = 12'h425;
    dat[3] = 12'h824;
    bus.fifo_in0    = dat[0];
    bus.fifo_in1    = dat[1];
    bus.fifo_in2    = dat[2];
    bus.fifo_in3    = dat[3];
    bus.empty       = 4'b1111;
    bus.almost_full = 1'b0;
    reset           = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_pop",      12'(bus.pop),  12'd0);
    check("rst_push",     12'(bus.push), 12'd0);
    check("rst_idle",     12'(bus.idle), 12'd1);
    check("rst_fifo_out", bus.fifo_out,  12'h000);
    @(negedge clk);
    reset = 1'b0;

    // All empty: nothing happens
    drain(4);
    check("empty_idle",     12'(bus.idle), 12'd1);
    check("empty_fifo_out", bus.fifo_out,  12'h000);

    // All non-empty: strict rotation starting at channel 0
    step(4'b0000, 1'b0, 4'b0001, "rr_pop0");
    step(4'b0000, 1'b0, 4'b0010, "rr_pop1");
    check("busy_idle", 12'(bus.idle), 12'd0);
    step(4'b0000, 1'b0, 4'b0100, "rr_pop2");
    step(4'b0000, 1'b0, 4'b1000, "rr_pop3");
    step(4'b0000, 1'b0, 4'b0001, "rr_pop4");
    step(4'b0000, 1'b0, 4'b0010, "rr_pop5");
    drain(3);
    check("drained_idle", 12'(bus.idle), 12'd1);

    // Single non-empty channel popped every cycle
    p0 = npush;
    for (int i = 0; i < 5; i++) step(4'b1011, 1'b0, 4'b0100, "solo_pop2");
    drain(3);
    check("solo_push_count", 12'(npush - p0), 12'd5);

    // almost_full during streaming (last grant is 2 here)
    step(4'b0000, 1'b0, 4'b1000, "af_pre3");
    step(4'b0000, 1'b0, 4'b0001, "af_pre0");
    step(4'b0000, 1'b0, 4'b0010, "af_pre1");
    p0 = npush;
    step(4'b0000, 1'b1, 4'b0000, "af_block");
    step(4'b0000, 1'b1, 4'b0000, "af_block");
    step(4'b0000, 1'b1, 4'b0000, "af_block");
    check("af_inflight_pushes", 12'(npush - p0), 12'd2);
    step(4'b0000, 1'b0, 4'b0100, "af_resume2");
    step(4'b0000, 1'b0, 4'b1000, "af_resume3");
    drain(3);

    // Channel 1 empties right when it is next in line
    step(4'b0000, 1'b0, 4'b0001, "skip_pop0");
    step(4'b0010, 1'b0, 4'b0100, "skip_pop2");
    drain(3);

    // Asynchronous reset between edges while pushing (last grant is 2 here)
    step(4'b0000, 1'b0, 4'b1000, "prer_pop3");
    step(4'b0000, 1'b0, 4'b0001, "prer_pop0");
    step(4'b0000, 1'b0, 4'b0010, "prer_pop1");
    #1;
    check("prer_push", 12'(bus.push), 12'd1);
    reset = 1'b1;
    #1;
    check("arst_push",     12'(bus.push), 12'd0);
    check("arst_pop",      12'(bus.pop),  12'd0);
    check("arst_fifo_out", bus.fifo_out,  12'h000);
    check("arst_idle",     12'(bus.idle), 12'd1);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    step(4'b0000, 1'b0, 4'b0000, "rel_no_pop");
    step(4'b0000, 1'b0, 4'b0001, "rel_pop0");
    step(4'b0000, 1'b0, 4'b0010, "rel_pop1");
    drain(3);

    check("sb_left", 12'(sb.size()), 12'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
